// File: rtl/mc14500_fetch.sv
// MC14500 instruction fetcher: streams bytes from an SPI flash READ,
// reopening the transaction whenever the requested PC is not sequential.
module mc14500_fetch #(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          PC_W       = 17
) (
    input  logic            i_clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    input  logic            fetch_req,
    output logic [7:0]      instr,
    output logic            instr_valid,
    output logic            busy,
    output logic            spi_cs_n,
    output logic            spi_sck,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESEL,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    state_t          state;
    logic            phase;
    logic [5:0]      bit_cnt;
    logic [31:0]     tx;
    logic [7:0]      rx;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] last_pc;
    logic            last_ok;

    logic            accept;
    logic            seq;
    logic [31:0]     cmd_word;

    assign accept   = fetch_req && !busy;
    assign cmd_word = {8'h03, FLASH_BASE + 24'(pc)};
    // A wrap from all-ones back to zero must reopen the read
    assign seq      = last_ok && (last_pc != '1) &&
                      (pc == last_pc + PC_W'(1));

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            bit_cnt     <= 6'd0;
            tx          <= 32'd0;
            rx          <= 8'd0;
            pc_q        <= '0;
            last_pc     <= '0;
            last_ok     <= 1'b0;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_sck     <= 1'b0;
            spi_mosi    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_CMD;
                        busy     <= 1'b1;
                        pc_q     <= pc;
                        spi_cs_n <= 1'b0;
                        phase    <= 1'b0;
                        bit_cnt  <= 6'd0;
                        spi_mosi <= cmd_word[31];
                        tx       <= {cmd_word[30:0], 1'b0};
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        pc_q  <= pc;
                        phase <= 1'b0;
                        if (seq) begin
                            state   <= S_DATA;
                            bit_cnt <= 6'd32;
                        end else begin
                            state    <= S_DESEL;
                            spi_cs_n <= 1'b1;
                            bit_cnt  <= 6'd0;
                            tx       <= cmd_word;
                        end
                    end
                end
                S_DESEL: begin
                    if (phase) begin
                        state    <= S_CMD;
                        phase    <= 1'b0;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= tx[31];
                        tx       <= {tx[30:0], 1'b0};
                    end else begin
                        phase <= 1'b1;
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (!phase) begin
                        phase   <= 1'b1;
                        spi_sck <= 1'b1;
                    end else begin
                        phase   <= 1'b0;
                        spi_sck <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        tx      <= {tx[30:0], 1'b0};
                        if (state == S_DATA)
                            rx <= {rx[6:0], spi_miso};
                        if (bit_cnt == 6'd39) begin
                            state       <= S_HOLD;
                            bit_cnt     <= 6'd0;
                            instr       <= {rx[6:0], spi_miso};
                            instr_valid <= 1'b1;
                            busy        <= 1'b0;
                            last_pc     <= pc_q;
                            last_ok     <= 1'b1;
                            spi_mosi    <= 1'b0;
                        end else if (bit_cnt >= 6'd31) begin
                            state    <= S_DATA;
                            spi_mosi <= 1'b0;
                        end else begin
                            if (bit_cnt == 6'd7)
                                state <= S_ADDR;
                            spi_mosi <= tx[31];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mc14500_fetch.md
# mc14500_fetch

SPI-flash instruction fetcher for the MC14500 computer. It sits directly upstream of the CPU and turns a program-counter request into an 8-bit instruction/address byte, which the CPU wrapper presents on its instruction input. Sequential PCs are streamed from a single open flash READ transaction; any discontinuity restarts the transaction. While `busy` is high, the CPU wrapper stalls its clock divider.

## Interface
Parameters:
- `FLASH_BASE`, default 24'h000000: flash byte address of PC 0.
- `PC_W`, default 17: program counter width, maximum 24.

Ports:
- `i_clk` in 1: sole clock; all state is updated on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in PC_W: requested instruction address; sampled only on an accepted request.
- `fetch_req` in 1: request strobe; accepted only when `busy`=0.
- `instr` out 8: fetched byte; held until the next `instr_valid`.
- `instr_valid` out 1: one-cycle pulse when `instr` updates.
- `busy` out 1: high from the acceptance edge until the edge that raises `instr_valid`.
- `spi_cs_n` out 1: flash chip select.
- `spi_sck` out 1: SPI clock, mode 0, frequency i_clk/2.
- `spi_mosi` out 1: command/address data, MSB first.
- `spi_miso` in 1: flash data.

## Operation
- States:
  - IDLE: cs_n=1.
  - DESEL: cs_n=1, lasts 2 cycles.
  - CMD: 8 bits.
  - ADDR: 24 bits.
  - DATA: 8 bits.
  - HOLD: cs_n=0, sck=0, waiting for the next request.
- Flash address = `FLASH_BASE` + zero-extended `pc`, computed modulo 2^24.
- Command byte is 8'h03 (READ), followed by the address MSB first.
- Each bit lasts 2 cycles:
  - Phase 0: sck=0, mosi driven stable.
  - Phase 1: sck=1.
  - At the edge ending phase 1, sck returns to 0 and miso is shifted into the receive register MSB first. This sample happens in DATA only.
- mosi=0 during DATA, HOLD, IDLE and DESEL.
- IDLE + accepted req → CMD (cs_n falls at the acceptance edge).
- CMD → ADDR → DATA, strictly in that order.
- DATA, last sample edge:
  - `instr` ← received byte.
  - `instr_valid`=1 for one cycle.
  - Save last_pc ← pc.
  - Go to HOLD.
- HOLD + accepted req:
  - If `pc` == last_pc+1 and last_pc != all-ones (sequential), go to DATA directly; cs_n stays low.
  - Otherwise go to DESEL (cs_n rises at the acceptance edge), then CMD.
- PC wrap (last_pc = all-ones, new pc = 0) is non-sequential and restarts the transaction.
- `fetch_req` while `busy`=1 is ignored; no queueing, no error.
- `fetch_req` and `instr_valid` in the same cycle: the request is accepted, since `busy` is already 0 in that cycle.

## Timing
- Reset values, all applied asynchronously:
  - State IDLE; cs_n=1, sck=0, mosi=0.
  - instr=8'h00, instr_valid=0, busy=0.
  - last_pc invalid, so the first fetch after reset is always non-sequential.
- Latency is measured from the acceptance edge E to the edge that raises `instr_valid`:
  - From IDLE: E+80 (40 bits × 2 cycles).
  - Non-sequential from HOLD: E+82.
  - Sequential from HOLD: E+16.
- `busy` rises at E and falls at the same edge `instr_valid` rises.
- Reset mid-transaction: cs_n rises immediately with no clock edge, and any partial byte is discarded. The next fetch issues a full command.
- cs_n high time between transactions is at least 2 cycles.
- An internal bit counter covers 0..39; sck toggles only in CMD, ADDR and DATA.

## Test plan
- Reset, flash[0]=8'hA5, req pc=0 → mosi carries 03 00 00 00; cs_n low from E; instr=8'hA5 with a 1-cycle `instr_valid` at E+80; `busy` high for exactly 80 cycles.
- Then req pc=1, flash[1]=8'h3C → cs_n stays low, no command bits, instr=8'h3C at E+16.
- Then req pc=0x00100 → cs_n high for 2 cycles, mosi 03 00 01 00, instr=flash[0x100] at E+82. Repeat with FLASH_BASE=24'h010000 → address bytes 01 01 00.
- Pulse `fetch_req` with pc=5 during the ADDR phase of a pending fetch → ignored; only one `instr_valid`, carrying the original byte; `busy` timing unchanged.
- PC_W=17: fetch pc=17'h1FFFF, then pc=0 → second fetch restarts with DESEL and command 03 00 00 00, not a streamed read.
- Assert `rst` during the 10th address bit → cs_n=1, sck=0, busy=0, instr=0 in the same cycle. After release, req pc=2 → full command sequence, valid at E+80.
